// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 core and its boot-time program loader:
// loader state encoding, loader error codes and the HALT opcode.
// No ports; imported with `import mips32_pkg::*;`.
package mips32_pkg;

  // Loader session states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    CHK  = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } ldr_state_e;

  // Reason the loader stopped in ERR.
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2
  } err_code_e;

  // Opcode the core treats as HALT.
  localparam logic [5:0] HALT_OPCODE = 6'h3f;

endpackage

// File: rtl/mips32_prog_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words.
// Ports: clk1/rst_n, clr (restart word alignment), take (byte accepted this
// cycle), in_data; word/word_valid are combinational on the 4th byte's take.
module mips32_prog_loader_byte_packer (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (take) begin
      // Counter wraps 3 -> 0, so the next word starts aligned.
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], in_data};
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // The 4th byte is not registered: it completes the word in the same cycle.
  assign word       = {shift_q, in_data};
  assign word_valid = take && (cnt_q == 2'd3);

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot loader: takes header N, N program words and an XOR checksum over a
// byte stream, writes the words to core memory from address 0, then releases
// the core. Ports: clk1/rst_n; start pulse; in_data/in_valid/in_ready byte
// stream; mem_we/mem_addr/mem_wdata write port (1 cycle after the 4th byte);
// cpu_hold/cpu_pc_clr core control; done/err/err_code status.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_pc_clr,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  ldr_state_e        state_q, state_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;  // one extra bit: N = MEM_DEPTH cannot wrap
  logic [ADDR_W:0]   len_q, len_d;
  logic [31:0]       csum_q, csum_d;
  err_code_e         err_code_q, err_code_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              pc_clr_q, pc_clr_d;

  logic              take;
  logic              enter_hdr;
  logic [31:0]       word;
  logic              word_valid;
  logic [ADDR_W:0]   word_cnt_inc;

  assign take         = in_valid && in_ready;
  assign enter_hdr    = (state_d == HDR) && (state_q != HDR);
  assign word_cnt_inc = word_cnt_q + CNT_ONE;

  mips32_prog_loader_byte_packer u_packer (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clr        (enter_hdr),
    .take       (take),
    .in_data    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start only matters outside an active session.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN, ERR: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (word_valid) begin
          if (word > 32'(MEM_DEPTH))  state_d = ERR;
          else if (word == 32'd0)     state_d = CHK;
          else                        state_d = LOAD;
        end
      end
      LOAD: begin
        if (word_valid && (word_cnt_inc == len_q)) state_d = CHK;
      end
      CHK: begin
        if (word_valid) state_d = (word == csum_q) ? RUN : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: counters, checksum, write port, error code.
  always_comb begin
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    csum_d      = csum_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_clr_d    = (state_d == RUN) && (state_q != RUN);

    if (enter_hdr) begin
      word_cnt_d = '0;
      len_d      = '0;
      csum_d     = 32'd0;
      err_code_d = ERR_NONE;
    end

    case (state_q)
      HDR: begin
        if (word_valid) begin
          // Truncation is harmless: oversize headers go straight to ERR.
          len_d = word[ADDR_W:0];
          if (word > 32'(MEM_DEPTH)) err_code_d = ERR_LEN;
        end
      end
      LOAD: begin
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_cnt_q[ADDR_W-1:0];
          mem_wdata_d = word;
          csum_d      = csum_q ^ word;
          word_cnt_d  = word_cnt_inc;
        end
      end
      CHK: begin
        if (word_valid && (word != csum_q)) err_code_d = ERR_CSUM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q  <= '0;
      len_q       <= '0;
      csum_q      <= 32'd0;
      err_code_q  <= ERR_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      pc_clr_q    <= 1'b0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_clr_q    <= pc_clr_d;
    end
  end

  // Outputs.
  always_comb begin
    in_ready   = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
    cpu_hold   = (state_q != RUN);
    done       = (state_q == RUN);
    err        = (state_q == ERR);
    cpu_pc_clr = pc_clr_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    err_code   = err_code_q;
  end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Boot-time program loader placed directly upstream of the pipelined MIPS32 core.
- Accepts a byte stream through a valid/ready handshake and assembles it into 32-bit instruction words.
- Writes those words into the core's instruction/data memory starting at address 0 and verifies a trailing XOR checksum.
- Holds the core halted throughout the load, then releases it with PC cleared. This replaces hand-preloading of memory and of PC/HALTED/TAKEN_BRANCH.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the core memory; the maximum program length.
- ADDR_W, 10, memory word-address width; must equal clog2(MEM_DEPTH).

Ports:
- clk1  in  1  clock (the core's phase-1 clock); all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load session.
- in_data  in  8  stream byte, most significant byte of each word first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  word to write.
- cpu_hold  out  1  keeps the core halted (drives HALTED); high whenever the loader is not in RUN.
- cpu_pc_clr  out  1  one-cycle pulse on entry to RUN; the core clears PC and TAKEN_BRANCH.
- done  out  1  high in RUN.
- err  out  1  high in ERR.
- err_code  out  2  0 = none, 1 = length overflow, 2 = checksum mismatch.

Behaviour:
- Reset (asynchronous, while rst_n = 0):
  - State goes to IDLE.
  - in_ready, mem_we, cpu_pc_clr, done and err are 0; cpu_hold is 1.
  - mem_addr, mem_wdata and err_code are 0.
  - Byte counter, word counter and checksum accumulator are 0.
  - Reset mid-load abandons the session; memory contents already written are left as they are.
- Handshake:
  - A byte is taken when in_valid && in_ready at the clk1 edge.
  - in_ready is 1 only in HDR, LOAD and CHK.
  - in_data may change freely while in_valid = 0.
- Word assembly:
  - 2-bit byte counter; a 24-bit shift register holds the first three bytes.
  - The word completes on the 4th accepted byte as {shift[23:0], in_data}.
  - The byte counter wraps 3 -> 0.
- States and transitions:
  - IDLE: start -> HDR. Entering HDR clears the counters, the checksum, err and err_code.
  - HDR: the completed word is N, the program length in words.
    - N > MEM_DEPTH -> ERR with err_code 1.
    - N = 0 -> CHK.
    - Otherwise -> LOAD.
  - LOAD: each completed word is registered.
    - The following cycle drives mem_we = 1, mem_addr = word index (0..N-1) and mem_wdata = the word, so write latency is 1 cycle after the 4th byte's handshake.
    - The checksum accumulator XORs each word.
    - After word N-1 -> CHK.
  - CHK: the completed word is compared with the accumulator.
    - Equal -> RUN.
    - Not equal -> ERR with err_code 2.
  - RUN: done = 1, cpu_hold = 0. cpu_pc_clr pulses exactly one cycle on entry. start -> HDR, which re-holds the core.
  - ERR: err = 1, cpu_hold = 1, memory writes inhibited. start -> HDR.
- start received in HDR, LOAD or CHK is ignored; an in-progress session is never restarted.
- N = MEM_DEPTH is legal; the last write goes to address MEM_DEPTH-1. The word counter is ADDR_W+1 bits so it cannot wrap.
- The header word and the checksum word are never written to memory.
- Bytes arriving in IDLE, RUN or ERR are not accepted (in_ready = 0).

Decomposition:
- Shared package mips32_pkg:
  - Loader state encoding: IDLE, HDR, LOAD, CHK, RUN, ERR.
  - err_code constants: ERR_NONE, ERR_LEN, ERR_CSUM.
  - HALT opcode 6'h3f, shared with the core.
- One natural sub-module, byte_packer: the byte counter plus shift register, producing word and word_valid.
- The FSM, counters and checksum stay in the top module.

Test Plan:
1. Nominal load. start, then header 9, then the nine words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 as bytes, then their XOR as the checksum.
   - Required: nine mem_we pulses at addresses 0..8 with exactly those data.
   - Then done = 1, cpu_hold = 0 and a single cpu_pc_clr pulse.
   - With the core attached, Reg1..Reg5 end at 10, 20, 25, 30, 55.
2. Throttled stream. Same program with in_valid toggling randomly.
   - Required: identical writes in identical order; no byte lost or duplicated.
3. Bad checksum. Checksum word XORed with 1.
   - Required: err = 1, err_code = 2, cpu_hold stays 1, cpu_pc_clr never pulses.
4. Overflow and empty program.
   - Header 1025 (MEM_DEPTH = 1024) -> ERR with err_code 1 and zero mem_we pulses.
   - Header 0 with checksum 0 -> RUN with no writes.
5. Reset mid-load. rst_n low after word 4.
   - Required: outputs return to reset values immediately (asynchronous).
   - Then start plus a full reload -> correct RUN.
6. Restart after RUN. start while in RUN.
   - Required: cpu_hold rises the next cycle, and a second program loads over the first.
